mlp_test_sequencer: RTL and testbench

Initiator-side controller that drives the MLP core's test interface: a reset pulse, a one-cycle start, and a 10-bit test number. It then collects each 4-bit prediction on done. It runs a batch of consecutive test numbers, compares each prediction with the expected label from an external label ROM, and keeps correct/timeout tallies. It sits between the host/top level and the MLP instance and replaces the manual reset/start/wait sequencing.

---
 rtl/mlp_test_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_mlp_test_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_test_sequencer.sv
// Batch test sequencer for the MLP core: pulses the core reset, issues a
// one-cycle start per test number, collects the prediction on done (or
// abandons the test after a timeout), scores it against the label ROM and
// keeps correct/timeout tallies for the batch.
module mlp_test_sequencer #(
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [9:0]  first_num,
  input  logic [10:0] num_tests,
  output logic        mlp_rst,
  output logic        mlp_start,
  output logic [9:0]  mlp_test_num,
  input  logic [3:0]  mlp_out,
  input  logic        mlp_done,
  output logic [9:0]  label_addr,
  input  logic [3:0]  label_data,
  output logic        result_valid,
  output logic [9:0]  result_num,
  output logic [3:0]  result_pred,
  output logic        result_correct,
  output logic        result_timeout,
  output logic [10:0] correct_count,
  output logic [10:0] timeout_count,
  output logic        busy,
  output logic        finished
);

  typedef enum logic [2:0] {
    IDLE,
    RSTP,
    START,
    WAIT,
    CHECK,
    NEXT,
    FIN
  } state_t;

  // Last value of the reset-pulse counter and the timer value that abandons a test
  localparam logic [3:0]  RST_LAST = 4'(RST_CYCLES - 1);
  localparam logic [15:0] TMO_LIM  = 16'(TIMEOUT);

  state_t state, state_nxt;

  logic [3:0]  rst_cnt;
  logic [15:0] timer;
  logic [10:0] remaining;
  logic [9:0]  test_num;

  // Capture registers filled when WAIT ends, consumed in CHECK
  logic [3:0]  pred_q;
  logic        tout_q;

  // Held copies of the last reported result, shown between result pulses
  logic [9:0]  res_num_q;
  logic [3:0]  res_pred_q;
  logic        res_correct_q;
  logic        res_timeout_q;

  logic rst_last;
  logic wait_tout;
  logic last_test;
  logic pred_match;
  logic in_check;

  assign rst_last   = (rst_cnt == RST_LAST);
  assign wait_tout  = (timer == TMO_LIM);
  assign last_test  = (remaining == 11'd1);
  // label_data is settled by CHECK because the address only moves in NEXT
  assign pred_match = (pred_q == label_data) && !tout_q;
  assign in_check   = (state == CHECK);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (go) begin
          state_nxt = (num_tests == 11'd0) ? FIN : RSTP;
        end
      end
      RSTP: begin
        if (rst_last) begin
          state_nxt = START;
        end
      end
      START: state_nxt = WAIT;
      WAIT: begin
        // done and timeout in the same cycle both land in CHECK; the
        // datapath below lets done win the capture
        if (mlp_done || wait_tout) begin
          state_nxt = CHECK;
        end
      end
      CHECK: state_nxt = NEXT;
      NEXT: state_nxt = last_test ? FIN : RSTP;
      FIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Batch bookkeeping, wait timer, prediction capture and result hold registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_cnt       <= '0;
      timer         <= '0;
      remaining     <= '0;
      test_num      <= '0;
      pred_q        <= '0;
      tout_q        <= 1'b0;
      res_num_q     <= '0;
      res_pred_q    <= '0;
      res_correct_q <= 1'b0;
      res_timeout_q <= 1'b0;
      correct_count <= '0;
      timeout_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            test_num      <= first_num;
            remaining     <= num_tests;
            correct_count <= '0;
            timeout_count <= '0;
            rst_cnt       <= '0;
          end
        end
        RSTP: begin
          rst_cnt <= rst_cnt + 4'd1;
        end
        START: begin
          timer <= '0;
        end
        WAIT: begin
          timer <= timer + 16'd1;
          if (mlp_done) begin
            pred_q <= mlp_out;
            tout_q <= 1'b0;
          end else if (wait_tout) begin
            pred_q <= '0;
            tout_q <= 1'b1;
          end
        end
        CHECK: begin
          res_num_q     <= test_num;
          res_pred_q    <= pred_q;
          res_correct_q <= pred_match;
          res_timeout_q <= tout_q;
          if (tout_q) begin
            timeout_count <= timeout_count + 11'd1;
          end else if (pred_match) begin
            correct_count <= correct_count + 11'd1;
          end
        end
        NEXT: begin
          remaining <= remaining - 11'd1;
          if (!last_test) begin
            // 10-bit add wraps 1023 back to 0
            test_num <= test_num + 10'd1;
            rst_cnt  <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Core reset follows the controller reset as well, so the core is held
  // in reset for as long as the sequencer is
  assign mlp_rst      = rst | (state == RSTP);
  assign mlp_start    = (state == START);
  assign mlp_test_num = test_num;
  assign label_addr   = test_num;

  assign busy         = (state != IDLE);
  assign finished     = (state == FIN);

  // Result fields are live during the CHECK pulse and held afterwards
  assign result_valid   = in_check;
  assign result_num     = in_check ? test_num   : res_num_q;
  assign result_pred    = in_check ? pred_q     : res_pred_q;
  assign result_correct = in_check ? pred_match : res_correct_q;
  assign result_timeout = in_check ? tout_q     : res_timeout_q;

endmodule

// File: tb/tb_mlp_test_sequencer.sv
// Scoreboard bench for mlp_test_sequencer with a behavioural MLP core and a
// registered label ROM.
module tb_mlp_test_sequencer;

  localparam int RST_CYCLES = 2;
  localparam int TIMEOUT    = 50;

  logic        clk;
  logic        rst;
  logic        go;
  logic [9:0]  first_num;
  logic [10:0] num_tests;
  logic        mlp_rst;
  logic        mlp_start;
  logic [9:0]  mlp_test_num;
  logic [3:0]  mlp_out;
  logic        mlp_done;
  logic [9:0]  label_addr;
  logic [3:0]  label_data;
  logic        result_valid;
  logic [9:0]  result_num;
  logic [3:0]  result_pred;
  logic        result_correct;
  logic        result_timeout;
  logic [10:0] correct_count;
  logic [10:0] timeout_count;
  logic        busy;
  logic        finished;

  mlp_test_sequencer #(
    .RST_CYCLES(RST_CYCLES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .go            (go),
    .first_num     (first_num),
    .num_tests     (num_tests),
    .mlp_rst       (mlp_rst),
    .mlp_start     (mlp_start),
    .mlp_test_num  (mlp_test_num),
    .mlp_out       (mlp_out),
    .mlp_done      (mlp_done),
    .label_addr    (label_addr),
    .label_data    (label_data),
    .result_valid  (result_valid),
    .result_num    (result_num),
    .result_pred   (result_pred),
    .result_correct(result_correct),
    .result_timeout(result_timeout),
    .correct_count (correct_count),
    .timeout_count (timeout_count),
    .busy          (busy),
    .finished      (finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int num;
    int pred;
    int corr;
    int tout;
    int dly;
  } exp_t;

  exp_t q[$];

  int vec_cnt = 0;
  int err_cnt = 0;

  int          lat_tab[1024];
  bit          wrong_tab[1024];
  bit          nodone_tab[1024];
  logic [3:0]  rom[1024];

  int cyc = 0;
  int acc_cyc = 0;
  int start_cyc = 0;
  int rst_run = 0;
  int n_start = 0;
  int last_num = 0;
  bit want_first = 0;
  int exp_cc = 0;
  int exp_tc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] pred_of(input int n);
    return wrong_tab[n] ? (rom[n] ^ 4'h1) : rom[n];
  endfunction

  // Registered label ROM
  always @(posedge clk) label_data <= rom[label_addr];

  // Behavioural MLP: done rises lat cycles after the start edge, cleared by mlp_rst
  logic       m_run = 1'b0;
  int         m_cnt = 0;
  logic [9:0] m_num = '0;
  always @(posedge clk) begin
    if (mlp_rst) begin
      mlp_done <= 1'b0;
      m_run    <= 1'b0;
    end else if (mlp_start) begin
      m_run <= !nodone_tab[mlp_test_num];
      m_cnt <= 1;
      m_num <= mlp_test_num;
    end else if (m_run) begin
      if (m_cnt == lat_tab[m_num]) begin
        mlp_done <= 1'b1;
        mlp_out  <= pred_of(int'(m_num));
        m_run    <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: reset-pulse length, start timing, and scoreboard compare on result_valid
  always @(negedge clk) begin : mon
    exp_t e;
    if (mlp_start) begin
      n_start++;
      chk("rst_len", rst_run, RST_CYCLES);
      chk("start_rst_low", {31'd0, mlp_rst}, 0);
      rst_run = 0;
      start_cyc = cyc;
      if (want_first) begin
        chk("go2start", cyc - acc_cyc, RST_CYCLES);
        want_first = 0;
      end
    end else if (mlp_rst) begin
      rst_run++;
    end else begin
      rst_run = 0;
    end
    if (result_valid) begin
      if (q.size() == 0) begin
        chk("spurious_rv", 1, 0);
      end else begin
        e = q.pop_front();
        chk("res_num", result_num, e.num);
        chk("res_pred", result_pred, e.pred);
        chk("res_correct", result_correct, e.corr);
        chk("res_timeout", result_timeout, e.tout);
        chk("res_dly", cyc - start_cyc, e.dly);
        last_num = e.num;
      end
    end
  end

  task automatic start_batch(input int first, input int num);
    exp_t e;
    int n;
    exp_cc = 0;
    exp_tc = 0;
    for (int i = 0; i < num; i++) begin
      n = (first + i) % 1024;
      e.num = n;
      if (nodone_tab[n] || lat_tab[n] > TIMEOUT) begin
        e.pred = 0;
        e.corr = 0;
        e.tout = 1;
        e.dly  = TIMEOUT + 2;
        exp_tc++;
      end else begin
        e.pred = int'(pred_of(n));
        e.corr = (pred_of(n) == rom[n]) ? 1 : 0;
        e.tout = 0;
        e.dly  = lat_tab[n] + 2;
        exp_cc += e.corr;
      end
      q.push_back(e);
    end
    @(negedge clk);
    go = 1'b1;
    first_num = 10'(first);
    num_tests = 11'(num);
    @(posedge clk);
    #1 go = 1'b0;
    @(negedge clk);
    acc_cyc = cyc;
    chk("busy_after_go", {31'd0, busy}, 1);
    if (num > 0) want_first = 1;
  endtask

  task automatic wait_finish();
    int k;
    k = 0;
    while (!finished && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("finish_seen", {31'd0, finished}, 1);
    chk("correct_count", correct_count, exp_cc);
    chk("timeout_count", timeout_count, exp_tc);
    chk("queue_empty", q.size(), 0);
    @(negedge clk);
    chk("finish_pulse", {31'd0, finished}, 0);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("hold_num", result_num, last_num);
    chk("hold_cc", correct_count, exp_cc);
  endtask

  initial begin
    int k;
    int s0;
    for (int i = 0; i < 1024; i++) begin
      rom[i]        = 4'((i * 7 + 3) % 16);
      lat_tab[i]    = 8 + (i % 5);
      wrong_tab[i]  = 1'b0;
      nodone_tab[i] = 1'b0;
    end
    wrong_tab[6]  = 1'b1;
    nodone_tab[9] = 1'b1;
    lat_tab[40]   = TIMEOUT;
    lat_tab[41]   = TIMEOUT + 1;

    rst = 1'b1;
    go = 1'b0;
    first_num = '0;
    num_tests = '0;
    #1;
    chk("rst_mlp_rst", {31'd0, mlp_rst}, 1);
    chk("rst_start", {31'd0, mlp_start}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rv", {31'd0, result_valid}, 0);
    chk("rst_num", mlp_test_num, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_mlp_rst", {31'd0, mlp_rst}, 0);
    chk("idle_fin", {31'd0, finished}, 0);

    // Basic batch of 4 starting at 0
    s0 = n_start;
    start_batch(0, 4);
    wait_finish();
    chk("batch4_starts", n_start - s0, 4);

    // Mismatch on test 6
    start_batch(5, 3);
    wait_finish();

    // Timeout on test 9, batch continues
    start_batch(8, 3);
    wait_finish();

    // Test number wrap
    start_batch(1022, 3);
    wait_finish();

    // Empty batch: finished the cycle after go, counters cleared, no core activity
    s0 = n_start;
    start_batch(17, 0);
    chk("fin0_pulse", {31'd0, finished}, 1);
    chk("fin0_mlp_rst", {31'd0, mlp_rst}, 0);
    wait_finish();
    chk("fin0_starts", n_start - s0, 0);

    // Done on the timeout cycle wins; one cycle later is a timeout
    start_batch(40, 2);
    wait_finish();

    // go while busy is ignored
    start_batch(200, 2);
    repeat (6) @(negedge clk);
    go = 1'b1;
    first_num = 10'd300;
    num_tests = 11'd5;
    @(negedge clk);
    go = 1'b0;
    chk("busy_go_ignored", mlp_test_num, 200);
    wait_finish();

    // Asynchronous reset in the middle of WAIT
    start_batch(100, 3);
    k = 0;
    while (!mlp_start && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rst_test_start", {31'd0, mlp_start}, 1);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_mlp_rst", {31'd0, mlp_rst}, 1);
    chk("mid_busy", {31'd0, busy}, 0);
    chk("mid_start", {31'd0, mlp_start}, 0);
    chk("mid_rv", {31'd0, result_valid}, 0);
    chk("mid_num", mlp_test_num, 0);
    chk("mid_res_num", result_num, 0);
    chk("mid_cc", correct_count, 0);
    q.delete();
    want_first = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_mlp_rst", {31'd0, mlp_rst}, 0);
    chk("post_rst_busy", {31'd0, busy}, 0);
    start_batch(100, 1);
    wait_finish();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
